// File: rtl/cache_lookup_stage.sv
// Pipelined tag lookup: accept -> array read -> compare/victim select -> registered result.
// Optional multi-way-hit detection is built only when LOOKUP_MULTIHIT_CHECK_EN is defined.
module cache_lookup_stage #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int SETS            = 1024,
  parameter int WAYS            = 2,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8))
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           lk_valid,
  output logic                           lk_ready,
  input  logic [ADDRESS_WIDTH-1:0]       lk_addr,
  input  logic                           lk_write,
  input  logic [CACHE_LINE_SIZE-1:0]     lk_wdata,
  input  logic [CACHE_LINE_SIZE/8-1:0]   lk_strobe,
  output logic                           mem_req,
  output logic [ADDRESS_WIDTH-1:0]       mem_addr,
  input  logic [WAYS*CACHE_LINE_SIZE-1:0] mem_data,
  input  logic [2*WAYS-1:0]              mem_vd,
  input  logic [WAYS*TAG_WIDTH-1:0]      mem_tag,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_hit,
  output logic [$clog2(WAYS)-1:0]        res_way,
  output logic [CACHE_LINE_SIZE-1:0]     res_data,
  output logic                           res_victim_dirty,
  output logic [TAG_WIDTH-1:0]           res_victim_tag,
  output logic [ADDRESS_WIDTH-1:0]       res_addr,
  output logic                           res_write,
  output logic [CACHE_LINE_SIZE-1:0]     res_wdata,
  output logic [CACHE_LINE_SIZE/8-1:0]   res_strobe,
  output logic                           err_multihit
);

  localparam int SET_BITS = $clog2(SETS);
  localparam int OFF_BITS = $clog2(CACHE_LINE_SIZE/8);
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int NODES    = WAYS - 1;
  localparam int BYTES    = CACHE_LINE_SIZE / 8;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NODES-1:0] tree);
    logic [WAY_BITS-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      v[WAY_BITS-1-l] = tree[n];
      n = 2*n + 1 + int'(tree[n]);
    end
    return v;
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                  input logic [WAY_BITS-1:0] way);
    logic [NODES-1:0] t;
    logic b;
    int n;
    t = tree;
    n = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b    = way[WAY_BITS-1-l];
      t[n] = ~b;
      n    = 2*n + 1 + int'(b);
    end
    return t;
  endfunction

  logic                         r_s1_valid;
  logic [ADDRESS_WIDTH-1:0]     r_s1_addr;
  logic                         r_s1_write;
  logic [CACHE_LINE_SIZE-1:0]   r_s1_wdata;
  logic [BYTES-1:0]             r_s1_strobe;

  logic                         r_out_valid;
  logic                         r_res_hit;
  logic [WAY_BITS-1:0]          r_res_way;
  logic [CACHE_LINE_SIZE-1:0]   r_res_data;
  logic                         r_res_victim_dirty;
  logic [TAG_WIDTH-1:0]         r_res_victim_tag;
  logic [ADDRESS_WIDTH-1:0]     r_res_addr;
  logic                         r_res_write;
  logic [CACHE_LINE_SIZE-1:0]   r_res_wdata;
  logic [BYTES-1:0]             r_res_strobe;

  logic [NODES-1:0]             r_plru [SETS];

  logic                         w_adv;
  logic                         w_accept;
  logic                         w_touch;
  logic [TAG_WIDTH-1:0]         w_s1_tag;
  logic [SET_BITS-1:0]          w_s1_set;
  logic [SET_BITS-1:0]          w_out_set;
  logic [NODES-1:0]             w_touch_tree;
  logic [NODES-1:0]             w_s1_tree;
  logic [WAY_BITS-1:0]          w_victim;
  logic [WAYS-1:0]              w_hit;
  logic [WAYS-1:0]              w_valid;
  logic                         w_any_hit;
  logic                         w_any_inv;
  logic [WAY_BITS-1:0]          w_hit_way;
  logic [WAY_BITS-1:0]          w_inv_way;
  logic [WAY_BITS-1:0]          w_sel_way;
  logic [CACHE_LINE_SIZE-1:0]   w_sel_data;
  logic [TAG_WIDTH-1:0]         w_sel_tag;
  logic                         w_sel_dirty_raw;
  logic                         w_sel_dirty;

  assign w_adv    = ~r_out_valid | res_ready;
  assign lk_ready = w_adv & ~flush & ~rst;
  assign w_accept = lk_valid & lk_ready;
  assign mem_req  = w_accept;
  assign mem_addr = lk_addr;

  assign w_s1_tag  = r_s1_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign w_s1_set  = r_s1_addr[OFF_BITS +: SET_BITS];
  assign w_out_set = r_res_addr[OFF_BITS +: SET_BITS];

  // Results dropped by flush do not age the replacement state.
  assign w_touch      = r_out_valid & res_ready & ~flush;
  assign w_touch_tree = plru_touch(r_plru[w_out_set], r_res_way);
  assign w_s1_tree    = (w_touch && (w_out_set == w_s1_set)) ? w_touch_tree : r_plru[w_s1_set];
  assign w_victim     = plru_victim(w_s1_tree);

  always_comb begin
    w_hit           = '0;
    w_valid         = '0;
    w_hit_way       = '0;
    w_inv_way       = '0;
    w_sel_way       = '0;
    w_sel_data      = '0;
    w_sel_tag       = '0;
    w_sel_dirty_raw = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_valid[w] = mem_vd[2*w];
      w_hit[w]   = mem_vd[2*w] && (mem_tag[w*TAG_WIDTH +: TAG_WIDTH] == w_s1_tag);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (w_hit[w])    w_hit_way = WAY_BITS'(w);
      if (!w_valid[w]) w_inv_way = WAY_BITS'(w);
    end
    w_any_hit = |w_hit;
    w_any_inv = ~&w_valid;
    if (w_any_hit)      w_sel_way = w_hit_way;
    else if (w_any_inv) w_sel_way = w_inv_way;
    else                w_sel_way = w_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (w_sel_way == WAY_BITS'(w)) begin
        w_sel_data      = mem_data[w*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
        w_sel_tag       = mem_tag[w*TAG_WIDTH +: TAG_WIDTH];
        w_sel_dirty_raw = mem_vd[2*w+1];
      end
    end
    w_sel_dirty = ~w_any_hit & w_sel_dirty_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid         <= 1'b0;
      r_s1_addr          <= '0;
      r_s1_write         <= 1'b0;
      r_s1_wdata         <= '0;
      r_s1_strobe        <= '0;
      r_out_valid        <= 1'b0;
      r_res_hit          <= 1'b0;
      r_res_way          <= '0;
      r_res_data         <= '0;
      r_res_victim_dirty <= 1'b0;
      r_res_victim_tag   <= '0;
      r_res_addr         <= '0;
      r_res_write        <= 1'b0;
      r_res_wdata        <= '0;
      r_res_strobe       <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= w_accept;
      r_out_valid <= r_s1_valid;
      if (w_accept) begin
        r_s1_addr   <= lk_addr;
        r_s1_write  <= lk_write;
        r_s1_wdata  <= lk_wdata;
        r_s1_strobe <= lk_strobe;
      end
      if (r_s1_valid) begin
        r_res_hit          <= w_any_hit;
        r_res_way          <= w_sel_way;
        r_res_data         <= w_sel_data;
        r_res_victim_dirty <= w_sel_dirty;
        r_res_victim_tag   <= w_sel_tag;
        r_res_addr         <= r_s1_addr;
        r_res_write        <= r_s1_write;
        r_res_wdata        <= r_s1_wdata;
        r_res_strobe       <= r_s1_strobe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (w_touch) begin
      r_plru[w_out_set] <= w_touch_tree;
    end
  end

  assign res_valid        = r_out_valid;
  assign res_hit          = r_res_hit;
  assign res_way          = r_res_way;
  assign res_data         = r_res_data;
  assign res_victim_dirty = r_res_victim_dirty;
  assign res_victim_tag   = r_res_victim_tag;
  assign res_addr         = r_res_addr;
  assign res_write        = r_res_write;
  assign res_wdata        = r_res_wdata;
  assign res_strobe       = r_res_strobe;

`ifdef LOOKUP_MULTIHIT_CHECK_EN
  logic r_err_multihit;
  logic w_multihit;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign w_multihit = r_s1_valid && ((w_hit & (w_hit - WAYS'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst)             r_err_multihit <= 1'b0;
    else if (w_multihit) r_err_multihit <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!w_multihit) else $warning("cache_lookup_stage: multiple ways hit in one set");
  end
`endif

  assign err_multihit = r_err_multihit;
`else
  assign err_multihit = 1'b0;
`endif

endmodule

// File: tb/tb_cache_lookup_stage.sv
// Scoreboard bench for cache_lookup_stage: directed lookups push expected results,
// a monitor pops and compares on every result handshake.
module tb_cache_lookup_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        lk_valid;
  logic        lk_ready;
  logic [31:0] lk_addr;
  logic        lk_write;
  logic [31:0] lk_wdata;
  logic [3:0]  lk_strobe;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [3:0]  mem_vd;
  logic [39:0] mem_tag;
  logic        res_valid;
  logic        res_ready;
  logic        res_hit;
  logic [0:0]  res_way;
  logic [31:0] res_data;
  logic        res_victim_dirty;
  logic [19:0] res_victim_tag;
  logic [31:0] res_addr;
  logic        res_write;
  logic [31:0] res_wdata;
  logic [3:0]  res_strobe;
  logic        err_multihit;

  cache_lookup_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_write(lk_write),
    .lk_wdata(lk_wdata), .lk_strobe(lk_strobe),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_vd(mem_vd), .mem_tag(mem_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_way(res_way),
    .res_data(res_data), .res_victim_dirty(res_victim_dirty), .res_victim_tag(res_victim_tag),
    .res_addr(res_addr), .res_write(res_write), .res_wdata(res_wdata), .res_strobe(res_strobe),
    .err_multihit(err_multihit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: 1-cycle read latency, outputs hold between requests.
  logic [19:0] m_tag0  [1024];
  logic [19:0] m_tag1  [1024];
  logic [31:0] m_data0 [1024];
  logic [31:0] m_data1 [1024];
  logic [3:0]  m_vd    [1024];

  always @(posedge clk) begin
    if (mem_req) begin
      mem_data <= {m_data1[mem_addr[11:2]], m_data0[mem_addr[11:2]]};
      mem_tag  <= {m_tag1[mem_addr[11:2]], m_tag0[mem_addr[11:2]]};
      mem_vd   <= m_vd[mem_addr[11:2]];
    end
  end

  typedef struct packed {
    logic        hit;
    logic        way;
    logic [31:0] data;
    logic        dirty;
    logic [19:0] vtag;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && !flush && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got addr %0h expected no result", res_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("res_hit",          64'(res_hit),          64'(mon_e.hit));
        chk("res_way",          64'(res_way),          64'(mon_e.way));
        chk("res_data",         64'(res_data),         64'(mon_e.data));
        chk("res_victim_dirty", 64'(res_victim_dirty), 64'(mon_e.dirty));
        chk("res_victim_tag",   64'(res_victim_tag),   64'(mon_e.vtag));
        chk("res_addr",         64'(res_addr),         64'(mon_e.addr));
        chk("res_write",        64'(res_write),        64'(mon_e.write));
        chk("res_wdata",        64'(res_wdata),        64'(mon_e.wdata));
        chk("res_strobe",       64'(res_strobe),       64'(mon_e.strobe));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                      input logic eh, input logic ew, input logic [31:0] ed, input logic edt,
                      input logic [19:0] et);
    exp_t e;
    int   n;
    lk_valid  = 1'b1;
    lk_addr   = a;
    lk_write  = w;
    lk_wdata  = wd;
    lk_strobe = st;
    n = 0;
    #1;
    while (!lk_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
    e = '{hit: eh, way: ew, data: ed, dirty: edt, vtag: et, addr: a, write: w, wdata: wd, strobe: st};
    sb.push_back(e);
    @(negedge clk);
    lk_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    lk_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lk_ready",  64'(lk_ready),     64'(0));
    chk("rst_res_valid", 64'(res_valid),    64'(0));
    chk("rst_res_data",  64'(res_data),     64'(0));
    chk("rst_res_addr",  64'(res_addr),     64'(0));
    chk("rst_err",       64'(err_multihit), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_lk_ready", 64'(lk_ready), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_addr = '0; lk_write = 1'b0;
    lk_wdata = '0; lk_strobe = '0; res_ready = 1'b1;
    mem_data = '0; mem_vd = '0; mem_tag = '0;
    for (int s = 0; s < 1024; s++) begin
      m_tag0[s] = '0; m_tag1[s] = '0; m_data0[s] = '0; m_data1[s] = '0; m_vd[s] = '0;
    end
    do_reset();

    // Cold miss: latency and read request pulse
    lk_valid = 1'b1; lk_addr = 32'h0048D014; lk_write = 1'b0; lk_wdata = '0; lk_strobe = '0;
    #1;
    chk("t1_mem_req",  64'(mem_req),  64'(1));
    chk("t1_mem_addr", 64'(mem_addr), 64'h0048D014);
    sb.push_back('{hit: 1'b0, way: 1'b0, data: 32'h0, dirty: 1'b0, vtag: 20'h0,
                   addr: 32'h0048D014, write: 1'b0, wdata: 32'h0, strobe: 4'h0});
    @(negedge clk);
    lk_valid = 1'b0;
    #1;
    chk("t1_mem_req_off", 64'(mem_req),   64'(0));
    chk("t1_res_valid_s1", 64'(res_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("t1_res_valid_out", 64'(res_valid), 64'(1));
    @(negedge clk);
    wait_drain();

    // Hit in way 1, store fields carried through
    m_vd[5] = 4'b0100; m_tag1[5] = 20'h0048D; m_data1[5] = 32'hCAFEF00D;
    send(32'h0048D014, 1'b1, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 20'h0048D);
    wait_drain();

    // Full set: PLRU victims, including forwarding of a same-set touch into S1
    do_reset();
    m_vd[5] = 4'b0111; m_tag0[5] = 20'h1; m_tag1[5] = 20'h2;
    m_data0[5] = 32'h11111111; m_data1[5] = 32'h22222222;
    send(32'h00003014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11111111, 1'b1, 20'h1);
    send(32'h00001014, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h11111111, 1'b0, 20'h1);
    send(32'h00003014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 20'h2);
    send(32'h00004014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11111111, 1'b1, 20'h1);
    send(32'h00005014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 20'h2);
    wait_drain();

    // Back-pressure for 3 cycles, then release
    res_ready = 1'b0;
    send(32'h00001014, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h11111111, 1'b0, 20'h1);
    send(32'h00002014, 1'b1, 32'hA5A5A5A5, 4'h3, 1'b1, 1'b1, 32'h22222222, 1'b0, 20'h2);
    fork
      send(32'h00003014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11111111, 1'b1, 20'h1);
      begin
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("stall_res_valid", 64'(res_valid), 64'(1));
          chk("stall_res_addr",  64'(res_addr),  64'h00001014);
          chk("stall_res_hit",   64'(res_hit),   64'(1));
          chk("stall_res_way",   64'(res_way),   64'(0));
          chk("stall_lk_ready",  64'(lk_ready),  64'(0));
          chk("stall_mem_req",   64'(mem_req),   64'(0));
          @(negedge clk);
        end
        res_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with S1 and OUT occupied
    res_ready = 1'b0;
    send(32'h00003014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 20'h2);
    send(32'h00004014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 20'h2);
    flush = 1'b1; res_ready = 1'b1; lk_valid = 1'b1; lk_addr = 32'h00005014;
    #1;
    chk("flush_lk_ready", 64'(lk_ready), 64'(0));
    chk("flush_mem_req",  64'(mem_req),  64'(0));
    @(negedge clk);
    flush = 1'b0; lk_valid = 1'b0;
    sb.delete();
    #1;
    chk("post_flush_res_valid", 64'(res_valid), 64'(0));
    @(negedge clk);
    send(32'h00003014, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h22222222, 1'b0, 20'h2);
    wait_drain();

    // Both ways claim the same tag: lowest way wins
    do_reset();
    m_vd[5] = 4'b0101; m_tag0[5] = 20'h0048D; m_tag1[5] = 20'h0048D;
    m_data0[5] = 32'hAAAA5555; m_data1[5] = 32'hCAFEF00D;
    send(32'h0048D014, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hAAAA5555, 1'b0, 20'h0048D);
    wait_drain();
`ifdef LOOKUP_MULTIHIT_CHECK_EN
    #1;
    chk("multihit_set", 64'(err_multihit), 64'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("multihit_sticky", 64'(err_multihit), 64'(1));
    do_reset();
`else
    #1;
    chk("multihit_tied_off", 64'(err_multihit), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_lookup_stage.md
Name: cache_lookup_stage

Overview:
- Pipelined tag-lookup stage wrapped around the cache memory array.
- Accepts lookup requests from the cache controller front end and issues the 1-cycle-latency array read.
- Compares the returned per-way tags/valid bits, selects hit data or a replacement victim (tree-PLRU), and presents a registered result to the downstream miss/writeback controller over a valid/ready handshake.
- Sustains one lookup per cycle when not back-pressured.

Parameters:
ADDRESS_WIDTH, 32, byte address width
SETS, 1024, sets per way; power of two
WAYS, 2, associativity; power of two, >= 2
CACHE_LINE_SIZE, 32, line width in bits; multiple of 8
TAG_WIDTH, ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8)), tag bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  drop all in-flight lookups
lk_valid  in  1  lookup request valid
lk_ready  out  1  lookup request accepted when lk_valid & lk_ready
lk_addr  in  ADDRESS_WIDTH  lookup byte address
lk_write  in  1  lookup is a store
lk_wdata  in  CACHE_LINE_SIZE  store data, carried through
lk_strobe  in  CACHE_LINE_SIZE/8  store byte strobes, carried through
mem_req  out  1  array read request (read only, no write enables)
mem_addr  out  ADDRESS_WIDTH  array read address
mem_data  in  WAYS*CACHE_LINE_SIZE  way w line at [w*CACHE_LINE_SIZE +: CACHE_LINE_SIZE]
mem_vd  in  2*WAYS  way w valid at [2w], dirty at [2w+1]
mem_tag  in  WAYS*TAG_WIDTH  way w tag at [w*TAG_WIDTH +: TAG_WIDTH]
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid & res_ready
res_hit  out  1  1 = hit, 0 = miss
res_way  out  $clog2(WAYS)  hit way on hit, victim way on miss
res_data  out  CACHE_LINE_SIZE  line of res_way
res_victim_dirty  out  1  dirty bit of res_way (0 on hit)
res_victim_tag  out  TAG_WIDTH  tag stored in res_way
res_addr, res_write, res_wdata, res_strobe  out  as lk_*  request fields carried through
err_multihit  out  1  sticky multi-way-hit error

Behaviour:
- Pipeline:
  - S0 (accept): mem_req = lk_valid & lk_ready, combinational; mem_addr = lk_addr. Request fields are captured into S1 registers.
  - S1 (compare): array outputs are valid. hit[w] = valid[w] & (tag[w] == captured tag).
  - OUT: registered result. Latency from accept to res_valid is 2 cycles.
- Advance and ready:
  - adv = ~res_valid | res_ready.
  - lk_ready = adv & ~flush & ~rst.
  - On adv, S1 moves into OUT (OUT valid = S1 valid), and S1 loads the new accept or becomes empty.
  - When adv = 0, S1 and OUT hold. mem_req stays 0, so array outputs hold for the stalled S1.
  - All res_* outputs are stable while res_valid & ~res_ready.
- Hit/victim selection:
  - Hit: res_way = lowest-index matching way.
  - Miss: res_way = lowest-index invalid way if any, else the PLRU victim.
  - res_data / res_victim_tag come from res_way. res_victim_dirty = dirty[res_way] on miss, 0 on hit.
- PLRU state: SETS × (WAYS-1) flops, binary tree.
  - Node bit 0: victim in lower half; node bit 1: victim in upper half.
  - Touch way w: each node on w's path is set to point away from w.
  - Touch happens on the OUT handshake, to res_way (hit or miss).
  - If the touched set equals the S1 set in the same cycle, S1 uses the updated bits (forwarding).
- Reset:
  - S1/OUT valid = 0, all PLRU bits = 0, err_multihit = 0.
  - res_* data outputs = 0. lk_ready = 0 during rst, 1 the cycle after.
- flush: S1 and OUT valid cleared next edge. Any lk_valid in the flush cycle is not accepted. PLRU is not updated for dropped results.
- Same-set store/refill ordering is owned by the downstream controller; this block does no write forwarding.

Optional Feature:
LOOKUP_MULTIHIT_CHECK_EN
- Defined: in S1, if more than one hit[w] is set, err_multihit sets on the next edge and stays set until rst; a simulation assertion also fires. The result is still produced using the lowest-index hit.
- Undefined: err_multihit is tied 0 and no check logic is built.

Test Plan:
- After reset, lookup addr 0x0048D014 (set 5, tag 0x0048D) -> mem_req=1 for 1 cycle, res_valid 2 cycles later, res_hit=0, res_way=0, res_victim_dirty=0.
- Array set 5 way1 = {valid=1, dirty=0, tag 0x0048D, data 0xCAFEF00D}, same lookup -> res_hit=1, res_way=1, res_data=0xCAFEF00D.
- Set 5 both ways valid, tags 0x1/0x2, dirty way0 = 1, lookup tag 0x3 after reset -> miss, res_way=0, res_victim_dirty=1, res_victim_tag=0x1. Hit way0 then repeat tag 0x3 -> res_way=1.
- Back-to-back lookups with res_ready=0 for 3 cycles -> res_* stable, lk_ready=0, mem_req=0. After release, one result per cycle, in order.
- flush with S1 and OUT full -> res_valid=0 next cycle, PLRU unchanged, next lookup completes normally.
- With LOOKUP_MULTIHIT_CHECK_EN, both ways valid with tag 0x0048D -> res_way=0, err_multihit=1 and sticky until rst.
